// File: rtl/operand_seq_pkg.sv
// Shared definitions for the operand sequencer: FSM state encoding, default
// operand width, swap counter width and a helper for sizing the dwell counter.
package operand_seq_pkg;

  localparam int unsigned WidthDefault = 4;
  localparam int unsigned SwapCntW     = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StSelA = 2'b01,
    StSelB = 2'b10
  } state_e;

  // Bits needed to count 0..n-1, never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer: counts cycles while run is high and pulses expire for one cycle
// when the count reaches DWELL_CYCLES-1, then restarts from zero.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   run    - count enable; counter is held at zero while low
//   clear  - synchronous clear, overrides run
//   expire - high in the cycle the last dwell cycle is being counted
module dwell_timer
  import operand_seq_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam int unsigned     CntW   = cnt_width(DWELL_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DWELL_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire = run & (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run) begin
      cnt_d = '0;
    end else if (expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Operand sequencer: holds two operands for a downstream 2:1 mux and, while
// running, alternates the mux select between them with a fixed dwell time.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   data_in              - operand load bus
//   load_a, load_b       - capture data_in into operand A / B (both allowed)
//   start, stop          - begin / halt alternating (stop has priority)
//   inp1, inp2           - operand A / B to the mux
//   sel                  - mux select, 0 = A, 1 = B
//   busy                 - high while alternating
//   swap_count           - sel toggles since last start, wraps modulo 16
module operand_sequencer
  import operand_seq_pkg::*;
#(
  parameter int unsigned WIDTH        = WidthDefault,
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                load_a,
  input  logic                load_b,
  input  logic                start,
  input  logic                stop,
  output logic [WIDTH-1:0]    inp1,
  output logic [WIDTH-1:0]    inp2,
  output logic                sel,
  output logic                busy,
  output logic [SwapCntW-1:0] swap_count
);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      a_q, b_q;
  logic [SwapCntW-1:0]   swap_q, swap_d;
  logic                  running;
  logic                  expire;

  assign running = (state_q != StIdle);

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (running),
    .clear (stop),
    .expire(expire)
  );

  always_comb begin
    state_d = state_q;
    swap_d  = swap_q;
    if (stop) begin
      // Halting keeps swap_count, even if a dwell expires this cycle.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StSelA;
            swap_d  = '0;
          end
        end
        StSelA: begin
          if (expire) begin
            state_d = StSelB;
            swap_d  = swap_q + SwapCntW'(1);
          end
        end
        StSelB: begin
          if (expire) begin
            state_d = StSelA;
            swap_d  = swap_q + SwapCntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      swap_q  <= '0;
    end else begin
      state_q <= state_d;
      swap_q  <= swap_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (load_a) a_q <= data_in;
      if (load_b) b_q <= data_in;
    end
  end

  // Outputs decode straight from registered state; no input reaches them combinationally.
  assign inp1       = a_q;
  assign inp2       = b_q;
  assign sel        = (state_q == StSelB);
  assign busy       = running;
  assign swap_count = swap_q;

endmodule
